// File: rtl/ras_ckpt_pkg.sv
// Shared constants and the checkpoint record for the return address stack.
// RAS_TOP_REPAIR_EN adds the checkpointed top-of-stack value to the record.
package ras_ckpt_pkg;

  localparam int RAS_ENTRIES      = 8;
  localparam int LOG_RAS_ENTRIES  = $clog2(RAS_ENTRIES);
  localparam int RAS_TARGET_WIDTH = 31;

  // Travels down the pipeline with each predicted branch.
  typedef struct packed {
    logic [LOG_RAS_ENTRIES-1:0] ptr;
    logic [LOG_RAS_ENTRIES:0]   count;
`ifdef RAS_TOP_REPAIR_EN
    logic [RAS_TARGET_WIDTH-1:0] top;
`endif
  } ras_ckpt_t;

endpackage

// File: rtl/ras_ckpt_if.sv
// Predict-stage and resolution-stage signals of the return address stack.
// RAS_TOP_REPAIR_EN adds ckpt_top/restore_top.
interface ras_ckpt_if #(
  parameter int ENTRIES      = ras_ckpt_pkg::RAS_ENTRIES,
  parameter int TARGET_WIDTH = ras_ckpt_pkg::RAS_TARGET_WIDTH,
  parameter int LOG_ENTRIES  = $clog2(ENTRIES)
);
  // Single-cycle strobes with no back-pressure: push_valid, pop_valid and
  // restore_valid act on the next posedge; restore_valid overrides push/pop.
  logic                    push_valid;
  logic [TARGET_WIDTH-1:0] push_target;
  logic                    pop_valid;
  logic                    top_valid;
  logic [TARGET_WIDTH-1:0] top_target;
  logic [LOG_ENTRIES-1:0]  ckpt_ptr;
  logic [LOG_ENTRIES:0]    ckpt_count;
  logic                    restore_valid;
  logic [LOG_ENTRIES-1:0]  restore_ptr;
  logic [LOG_ENTRIES:0]    restore_count;
`ifdef RAS_TOP_REPAIR_EN
  logic [TARGET_WIDTH-1:0] ckpt_top;
  logic [TARGET_WIDTH-1:0] restore_top;

  modport master (
    output push_valid, push_target, pop_valid,
    output restore_valid, restore_ptr, restore_count, restore_top,
    input  top_valid, top_target, ckpt_ptr, ckpt_count, ckpt_top
  );
  modport slave (
    input  push_valid, push_target, pop_valid,
    input  restore_valid, restore_ptr, restore_count, restore_top,
    output top_valid, top_target, ckpt_ptr, ckpt_count, ckpt_top
  );
`else
  modport master (
    output push_valid, push_target, pop_valid,
    output restore_valid, restore_ptr, restore_count,
    input  top_valid, top_target, ckpt_ptr, ckpt_count
  );
  modport slave (
    input  push_valid, push_target, pop_valid,
    input  restore_valid, restore_ptr, restore_count,
    output top_valid, top_target, ckpt_ptr, ckpt_count
  );
`endif
endinterface

// File: rtl/ras_ckpt_array.sv
// Return address storage: one synchronous write port, one asynchronous read port.
module ras_ckpt_array
  import ras_ckpt_pkg::*;
#(
  parameter int ENTRIES     = RAS_ENTRIES,
  parameter int WIDTH       = RAS_TARGET_WIDTH,
  parameter int LOG_ENTRIES = $clog2(ENTRIES)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   we_i,
  input  logic [LOG_ENTRIES-1:0] waddr_i,
  input  logic [WIDTH-1:0]       wdata_i,
  input  logic [LOG_ENTRIES-1:0] raddr_i,
  output logic [WIDTH-1:0]       rdata_o
);

  logic [WIDTH-1:0] mem_q [ENTRIES];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < ENTRIES; i++) mem_q[i] <= '0;
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/ras_ckpt.sv
// Circular return address stack with per-cycle checkpoint and one-cycle restore.
// RAS_TOP_REPAIR_EN: restore also rewrites the checkpointed top entry.
module ras_ckpt
  import ras_ckpt_pkg::*;
#(
  parameter int ENTRIES      = RAS_ENTRIES,
  parameter int TARGET_WIDTH = RAS_TARGET_WIDTH,
  parameter int LOG_ENTRIES  = $clog2(ENTRIES)
) (
  input  logic      CLK,
  input  logic      RST,
  ras_ckpt_if.slave ras
);

  localparam logic [LOG_ENTRIES:0]   FULL = (LOG_ENTRIES+1)'(ENTRIES);
  localparam logic [LOG_ENTRIES-1:0] ONE  = LOG_ENTRIES'(1);

  logic [LOG_ENTRIES-1:0]  ptr_q, ptr_d;
  logic [LOG_ENTRIES:0]    count_q, count_d;
  logic                    wr_en;
  logic [LOG_ENTRIES-1:0]  wr_addr;
  logic [TARGET_WIDTH-1:0] wr_data;
  logic [TARGET_WIDTH-1:0] top_data;

  always_comb begin
    ptr_d   = ptr_q;
    count_d = count_q;
    wr_en   = 1'b0;
    wr_addr = ptr_q;
    wr_data = ras.push_target;
    if (ras.restore_valid) begin
      ptr_d   = ras.restore_ptr;
      count_d = ras.restore_count;
`ifdef RAS_TOP_REPAIR_EN
      wr_en   = 1'b1;
      wr_addr = ras.restore_ptr;
      wr_data = ras.restore_top;
`endif
    end else if (ras.push_valid && ras.pop_valid) begin
      // Tail call: replace the top in place.
      wr_en = 1'b1;
    end else if (ras.push_valid) begin
      // A full stack silently overwrites its oldest entry.
      ptr_d   = ptr_q + ONE;
      wr_addr = ptr_q + ONE;
      wr_en   = 1'b1;
      count_d = (count_q == FULL) ? count_q : count_q + 1'b1;
    end else if (ras.pop_valid) begin
      ptr_d   = ptr_q - ONE;
      count_d = (count_q == '0) ? count_q : count_q - 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      ptr_q   <= '0;
      count_q <= '0;
    end else begin
      ptr_q   <= ptr_d;
      count_q <= count_d;
    end
  end

  ras_ckpt_array #(
    .ENTRIES     (ENTRIES),
    .WIDTH       (TARGET_WIDTH),
    .LOG_ENTRIES (LOG_ENTRIES)
  ) u_array (
    .clk_i   (CLK),
    .rst_i   (RST),
    .we_i    (wr_en),
    .waddr_i (wr_addr),
    .wdata_i (wr_data),
    .raddr_i (ptr_q),
    .rdata_o (top_data)
  );

  assign ras.top_valid  = (count_q != '0);
  assign ras.top_target = top_data;
  assign ras.ckpt_ptr   = ptr_q;
  assign ras.ckpt_count = count_q;
`ifdef RAS_TOP_REPAIR_EN
  assign ras.ckpt_top   = top_data;
`endif

endmodule

// File: tb/tb_ras_ckpt.sv
// Bench for ras_ckpt: reference stack model feeding an expected-state queue,
// plus directed checks of the documented scenarios. Honours RAS_TOP_REPAIR_EN.
module tb_ras_ckpt;
  import ras_ckpt_pkg::*;

  localparam int ENTRIES = 8;
  localparam int TW      = 31;
  localparam int SW      = 1 + 4 + 3 + TW;

  logic clk;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  ras_ckpt_if #(.ENTRIES(ENTRIES), .TARGET_WIDTH(TW)) bus ();

  ras_ckpt #(.ENTRIES(ENTRIES), .TARGET_WIDTH(TW)) dut (
    .CLK (clk),
    .RST (rst),
    .ras (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk)
    if (!rst && bus.restore_valid)
      assert (bus.restore_count <= 4'd8) else $error("FAIL restore_count_legal: got %0d", bus.restore_count);

  // reference model and scoreboard
  logic [TW-1:0] m_stack [ENTRIES];
  int            m_ptr;
  int            m_count;
  logic [TW-1:0] last_rtop;
  logic [SW-1:0] exp_q [$];
  logic [SW-1:0] exp_s;
  wire  [SW-1:0] obs = {bus.top_valid, bus.ckpt_count, bus.ckpt_ptr, bus.top_target};

  function automatic logic [SW-1:0] model_state();
    return {(m_count != 0), 4'(m_count), 3'(m_ptr), m_stack[m_ptr]};
  endfunction

  task automatic idle_inputs();
    bus.push_valid    = 1'b0;
    bus.push_target   = '0;
    bus.pop_valid     = 1'b0;
    bus.restore_valid = 1'b0;
    bus.restore_ptr   = '0;
    bus.restore_count = '0;
`ifdef RAS_TOP_REPAIR_EN
    bus.restore_top   = '0;
`endif
  endtask

  // Drives one cycle, advances the model, queues the expected post-edge state.
  task automatic drive(input logic rst_v, input logic push, input logic pop, input logic [TW-1:0] tgt,
                       input logic rv, input int rptr, input int rcnt, input logic [TW-1:0] rtop);
    @(negedge clk);
    rst               = rst_v;
    bus.push_valid    = push;
    bus.push_target   = tgt;
    bus.pop_valid     = pop;
    bus.restore_valid = rv;
    bus.restore_ptr   = 3'(rptr);
    bus.restore_count = 4'(rcnt);
    last_rtop         = rtop;
`ifdef RAS_TOP_REPAIR_EN
    bus.restore_top   = rtop;
`endif
    if (rst_v) begin
      for (int i = 0; i < ENTRIES; i++) m_stack[i] = '0;
      m_ptr   = 0;
      m_count = 0;
    end else if (rv) begin
      m_ptr   = rptr;
      m_count = rcnt;
`ifdef RAS_TOP_REPAIR_EN
      m_stack[rptr] = rtop;
`endif
    end else if (push && pop) begin
      m_stack[m_ptr] = tgt;
    end else if (push) begin
      m_ptr = (m_ptr + 1) % ENTRIES;
      m_stack[m_ptr] = tgt;
      if (m_count < ENTRIES) m_count++;
    end else if (pop) begin
      m_ptr = (m_ptr + ENTRIES - 1) % ENTRIES;
      if (m_count > 0) m_count--;
    end
    exp_q.push_back(model_state());
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle_inputs();
  endtask

  task automatic do_push(input logic [TW-1:0] t);
    drive(1'b0, 1'b1, 1'b0, t, 1'b0, 0, 0, '0);
  endtask

  task automatic do_pop();
    drive(1'b0, 1'b0, 1'b1, '0, 1'b0, 0, 0, '0);
  endtask

  task automatic do_reset();
    drive(1'b1, 1'b0, 1'b0, '0, 1'b0, 0, 0, '0);
    void'(exp_q.pop_front());
  endtask

  // scenarios
  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), TW'($urandom), 1'b0, 0, 0, '0);
      exp_s = exp_q.pop_front();
      n_tests++;
      if (obs !== exp_s || obs !== '0) begin
        n_fail++;
        $display("FAIL reset_state: got %h expected %h", obs, exp_s);
      end
    end
  endtask

  task automatic test_push_pop();
    logic [TW-1:0] pops [3] = '{31'h200, 31'h100, 31'h0};
    do_reset();
    do_push(31'h100); void'(exp_q.pop_front());
    do_push(31'h200); void'(exp_q.pop_front());
    do_push(31'h300);
    exp_s = exp_q.pop_front();
    n_tests++;
    if (obs !== exp_s || bus.top_target !== 31'h300 || bus.ckpt_count !== 4'd3 || bus.ckpt_ptr !== 3'd3) begin
      n_fail++;
      $display("FAIL push3: got %h expected %h (top 300 cnt 3 ptr 3)", obs, exp_s);
    end
    for (int i = 0; i < 3; i++) begin
      do_pop();
      exp_s = exp_q.pop_front();
      n_tests++;
      if (obs !== exp_s || bus.top_valid !== (i < 2) || (i < 2 && bus.top_target !== pops[i])) begin
        n_fail++;
        $display("FAIL pop_%0d: got %h expected %h", i, obs, exp_s);
      end
    end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int v = 1; v <= 9; v++) begin
      do_push(TW'(v));
      void'(exp_q.pop_front());
    end
    n_tests++;
    if (bus.ckpt_count !== 4'd8 || bus.ckpt_ptr !== 3'd1 || bus.top_target !== 31'h9) begin
      n_fail++;
      $display("FAIL wrap_full: got cnt %0d ptr %0d top %h expected 8 1 9", bus.ckpt_count, bus.ckpt_ptr, bus.top_target);
    end
    for (int i = 0; i < 8; i++) begin
      n_tests++;
      if (bus.top_target !== TW'(9 - i) || bus.top_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL wrap_pop_%0d: got %h expected %h", i, bus.top_target, TW'(9 - i));
      end
      do_pop();
      exp_s = exp_q.pop_front();
      n_tests++;
      if (obs !== exp_s) begin
        n_fail++;
        $display("FAIL wrap_state_%0d: got %h expected %h", i, obs, exp_s);
      end
    end
  endtask

  task automatic test_empty_pop();
    do_reset();
    do_pop();
    exp_s = exp_q.pop_front();
    n_tests++;
    if (obs !== exp_s || bus.ckpt_ptr !== 3'd7 || bus.ckpt_count !== 4'd0 || bus.top_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL empty_pop: got %h expected %h", obs, exp_s);
    end
    do_push(31'hA);
    exp_s = exp_q.pop_front();
    n_tests++;
    if (obs !== exp_s || bus.ckpt_ptr !== 3'd0 || bus.top_target !== 31'hA || bus.ckpt_count !== 4'd1) begin
      n_fail++;
      $display("FAIL push_after_empty: got %h expected %h", obs, exp_s);
    end
  endtask

  task automatic test_push_pop_same();
    do_reset();
    do_push(31'h40); void'(exp_q.pop_front());
    drive(1'b0, 1'b1, 1'b1, 31'h80, 1'b0, 0, 0, '0);
    exp_s = exp_q.pop_front();
    n_tests++;
    if (obs !== exp_s || bus.top_target !== 31'h80 || bus.ckpt_ptr !== 3'd1 || bus.ckpt_count !== 4'd1) begin
      n_fail++;
      $display("FAIL push_pop_same: got %h expected %h", obs, exp_s);
    end
  endtask

  task automatic test_restore();
    int            ck_ptr, ck_cnt;
    logic [TW-1:0] ck_top;
    do_reset();
    do_push(31'h10); void'(exp_q.pop_front());
    do_push(31'h20); void'(exp_q.pop_front());
    ck_ptr = m_ptr; ck_cnt = m_count; ck_top = m_stack[m_ptr];
    do_pop();         void'(exp_q.pop_front());
    do_push(31'hBAD); void'(exp_q.pop_front());
    drive(1'b0, 1'b0, 1'b0, '0, 1'b1, ck_ptr, ck_cnt, ck_top);
    exp_s = exp_q.pop_front();
    n_tests++;
`ifdef RAS_TOP_REPAIR_EN
    if (obs !== exp_s || bus.top_target !== 31'h20 || bus.ckpt_top !== 31'h20) begin
`else
    if (obs !== exp_s || bus.top_target !== 31'hBAD) begin
`endif
      n_fail++;
      $display("FAIL restore_top: got %h expected %h", obs, exp_s);
    end
    n_tests++;
    if (bus.ckpt_ptr !== 3'd2 || bus.ckpt_count !== 4'd2) begin
      n_fail++;
      $display("FAIL restore_ptr_cnt: got ptr %0d cnt %0d expected 2 2", bus.ckpt_ptr, bus.ckpt_count);
    end
    // restore beats a concurrent push
    drive(1'b0, 1'b1, 1'b0, 31'h55, 1'b1, 1, 1, 31'h10);
    exp_s = exp_q.pop_front();
    n_tests++;
    if (obs !== exp_s || bus.ckpt_ptr !== 3'd1 || bus.ckpt_count !== 4'd1 || bus.top_target !== 31'h10) begin
      n_fail++;
      $display("FAIL restore_over_push: got %h expected %h", obs, exp_s);
    end
  endtask

  task automatic test_reset_priority();
    do_push(31'h77); void'(exp_q.pop_front());
    drive(1'b1, 1'b1, 1'b0, 31'h99, 1'b1, 5, 3, 31'h33);
    exp_s = exp_q.pop_front();
    n_tests++;
    if (obs !== exp_s || obs !== '0) begin
      n_fail++;
      $display("FAIL reset_over_restore: got %h expected %h", obs, exp_s);
    end
  endtask

  task automatic test_random();
    int            ck_ptr = 0, ck_cnt = 0;
    logic [TW-1:0] ck_top = '0;
    do_reset();
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        ck_ptr = m_ptr; ck_cnt = m_count; ck_top = m_stack[m_ptr];
      end
      if ($urandom_range(0, 9) == 0)
        drive(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), TW'($urandom), 1'b1, ck_ptr, ck_cnt, ck_top);
      else
        drive(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), TW'($urandom), 1'b0, 0, 0, '0);
      exp_s = exp_q.pop_front();
      n_tests++;
      if (obs !== exp_s) begin
        n_fail++;
        $display("FAIL random_%0d: got %h expected %h", i, obs, exp_s);
      end
`ifdef RAS_TOP_REPAIR_EN
      n_tests++;
      if (bus.ckpt_top !== exp_s[TW-1:0]) begin
        n_fail++;
        $display("FAIL random_ckpt_top_%0d: got %h expected %h", i, bus.ckpt_top, exp_s[TW-1:0]);
      end
`endif
    end
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_push_pop();
    test_wrap();
    test_empty_pop();
    test_push_pop_same();
    test_restore();
    test_reset_priority();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ras_ckpt.md
# ras_ckpt

Parametrised return address stack (RAS) with checkpoint/restore for the branch prediction front end. It generalises the fixed 8-entry, 31-bit RAS into a configurable-depth, configurable-width circular stack. Predict-stage pushes/pops are speculative; every cycle the block publishes a checkpoint that travels with the branch, and a mispredict restores that checkpoint in one cycle. Sits beside the BTB/UPCT in the fetch predict stage; restore comes from the branch resolution path.

## Interface
- ENTRIES, 8: stack depth; power of two, ≥2
- TARGET_WIDTH, 31: stored return target width (PC[31:1])
- LOG_ENTRIES, $clog2(ENTRIES): derived pointer width
- CLK  input  1  clock; all state updates on posedge
- RST  input  1  synchronous, active-high reset
- push_valid  input  1  call predicted this cycle
- push_target  input  TARGET_WIDTH  return address to push
- pop_valid  input  1  return predicted this cycle
- top_valid  output  1  count != 0
- top_target  output  TARGET_WIDTH  stack[ptr], combinational from state
- ckpt_ptr  output  LOG_ENTRIES  current top pointer
- ckpt_count  output  LOG_ENTRIES+1  current occupancy
- ckpt_top  output  TARGET_WIDTH  copy of top_target (only with macro)
- restore_valid  input  1  mispredict repair this cycle
- restore_ptr  input  LOG_ENTRIES  checkpointed pointer
- restore_count  input  LOG_ENTRIES+1  checkpointed occupancy
- restore_top  input  TARGET_WIDTH  checkpointed top (only with macro)

## Operation
- State: stack[ENTRIES] of TARGET_WIDTH, ptr (points at top valid entry), count (0..ENTRIES).
- Priority per cycle: RST > restore_valid > push/pop. Restore cycle ignores push_valid/pop_valid.
- Push only: ptr <= ptr+1 (mod ENTRIES); stack[ptr+1] <= push_target; count <= min(count+1, ENTRIES). Full push overwrites oldest entry (circular overwrite, no stall).
- Pop only: ptr <= ptr-1 (mod ENTRIES); count <= max(count-1, 0). Pop at count 0: ptr still decrements, count stays 0, no error.
- Push+pop same cycle (tail call/coroutine): stack[ptr] <= push_target; ptr, count unchanged.
- Restore: ptr <= restore_ptr; count <= restore_count; stack untouched (base) or repaired (macro).
- Pointer arithmetic is modulo ENTRIES by natural LOG_ENTRIES-bit wrap.
- restore_count > ENTRIES is illegal input; behaviour undefined (assertion in bench).

## Timing
- Reset values: ptr=0, count=0, all stack entries 0; top_valid=0, top_target=0, ckpt_ptr=0, ckpt_count=0, ckpt_top=0.
- top_target/top_valid/ckpt_* are combinational from registered state: reflect all updates of the previous edge, zero-cycle read.
- Push/pop/restore take effect at the next posedge; prediction for a pop uses top_target in the same cycle pop_valid is asserted.
- Checkpoint sampled in cycle N describes state before cycle N's push/pop.
- RST asserted mid-sequence wins over any concurrent restore/push/pop.

## Configuration
- RAS_TOP_REPAIR_EN defined: ckpt_top/restore_top ports exist; on restore, stack[restore_ptr] <= restore_top in the same edge, repairing an entry clobbered by a wrong-path push.
- Undefined: ports absent; restore sets ptr/count only; wrong-path overwrites of live entries persist.

## Structure
- core_types_pkg gains RAS_ENTRIES, LOG_RAS_ENTRIES, RAS_TARGET_WIDTH usage plus typedef ras_ckpt_t {ptr, count, top (under macro)} for pipeline carriage.
- One natural sub-module: ras_array (ENTRIES×TARGET_WIDTH register file, one write port, one async read port); pointer/count logic lives in ras_ckpt.

## Test plan
- Reset then push 0x100, 0x200, 0x300 -> top_target=0x300, count=3, ptr=3; three pops -> 0x200, 0x100, then top_valid=0.
- ENTRIES=8: push 0x1..0x9 -> count=8, ptr=1, top=0x9; eight pops return 0x9..0x2; oldest 0x1 lost.
- Pop on empty -> count stays 0, ptr 0->7, top_valid=0; subsequent push 0xA writes stack[0], top=0xA.
- Top=0x40, push_valid+pop_valid with 0x80 -> top=0x80, ptr/count unchanged.
- Checkpoint (ptr=2,count=2,top=0x20), wrong-path pop then push 0xBAD, restore -> ptr=2, count=2; top=0x20 with RAS_TOP_REPAIR_EN, 0xBAD without.
- restore_valid and push_valid same cycle -> restore applied, push dropped; RST with restore_valid -> all reset values.
